// File: rtl/collide_seq_ctrl.sv
// Batch sequencer for the sphere-collision pipeline: clears the pipe, issues
// pair reads, writes results to output memory and flags timeouts/spurious results.
module collide_seq_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int PIPE_CLR = 2,
  parameter int TMO_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [ADDR_W-1:0] num_pairs,
  input  logic              done_collide,
  output logic              pipe_rst_n,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              in_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CLR_W = (PIPE_CLR > 1) ? $clog2(PIPE_CLR) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(PIPE_CLR - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

  typedef enum logic [2:0] {IDLE, CLR, ISSUE, DRAIN, FIN} state_e;

  state_e            state_q;
  logic              cs_q, pipe_rst_n_q, rd_en_q, in_valid_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0] n_q, rd_addr_q, res_cnt_q, res_cnt_d;
  logic [ADDR_W:0]   out_cnt_q;
  logic [CLR_W-1:0]  clr_cnt_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              start, accept, out_dec;

  assign start     = cs & ~cs_q;
  assign accept    = done_collide & busy_q;
  assign out_dec   = accept & (out_cnt_q != '0);
  // Results beyond the batch size are dropped so output memory is never overrun.
  assign wr_en     = accept & (res_cnt_q < n_q);
  assign res_cnt_d = res_cnt_q + ADDR_W'(wr_en);

  assign pipe_rst_n = pipe_rst_n_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign in_valid   = in_valid_q;
  assign wr_addr    = res_cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cs_q         <= 1'b0;
      pipe_rst_n_q <= 1'b1;
      rd_en_q      <= 1'b0;
      in_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      n_q          <= '0;
      rd_addr_q    <= '0;
      res_cnt_q    <= '0;
      out_cnt_q    <= '0;
      clr_cnt_q    <= '0;
      tmo_q        <= '0;
    end else begin
      cs_q       <= cs;
      in_valid_q <= rd_en_q;
      done_q     <= 1'b0;
      tmo_q      <= '0;
      res_cnt_q  <= res_cnt_d;
      if (accept && !out_dec) err_q <= 1'b1;
      if (in_valid_q && !out_dec)      out_cnt_q <= out_cnt_q + (ADDR_W+1)'(1);
      else if (!in_valid_q && out_dec) out_cnt_q <= out_cnt_q - (ADDR_W+1)'(1);

      case (state_q)
        IDLE: begin
          if (start) begin
            err_q     <= 1'b0;
            n_q       <= num_pairs;
            res_cnt_q <= '0;
            out_cnt_q <= '0;
            if (num_pairs == '0) begin
              state_q <= FIN;
            end else begin
              pipe_rst_n_q <= 1'b0;
              busy_q       <= 1'b1;
              clr_cnt_q    <= '0;
              state_q      <= CLR;
            end
          end
        end
        CLR: begin
          if (clr_cnt_q == CLR_LAST) begin
            pipe_rst_n_q <= 1'b1;
            rd_en_q      <= 1'b1;
            rd_addr_q    <= '0;
            state_q      <= ISSUE;
          end else begin
            clr_cnt_q <= clr_cnt_q + CLR_W'(1);
          end
        end
        ISSUE: begin
          if (rd_addr_q == n_q - ADDR_W'(1)) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (res_cnt_d == n_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FIN;
          end else if (!accept) begin
            if (tmo_q == TMO_LAST) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FIN;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
        end
        FIN: begin
          // An empty batch arrives here without done raised; raise it first.
          if (!done_q) done_q  <= 1'b1;
          else         state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_collide_seq_ctrl.sv
// Self-checking bench for collide_seq_ctrl with an event-level reference model
// and a fixed-latency pipeline emulator driving done_collide.
module tb_collide_seq_ctrl;
  localparam int PC = 2;

  logic       clk = 1'b0, rst = 1'b0, cs = 1'b0, done_collide = 1'b0;
  logic [7:0] num_pairs = 8'd0;
  logic       pipe_rst_n, rd_en, in_valid, wr_en, busy, done, err;
  logic [7:0] rd_addr, wr_addr;

  collide_seq_ctrl #(.ADDR_W(8), .PIPE_CLR(PC), .TMO_W(6)) dut (
    .clk(clk), .rst(rst), .cs(cs), .num_pairs(num_pairs), .done_collide(done_collide),
    .pipe_rst_n(pipe_rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .in_valid(in_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int lat = 5, keep = 1000, iv_cnt = 0;
  bit res_at [0:8191];
  bit extra_at [0:8191];
  int rd_c[$], rd_a[$], wr_c[$], wr_a[$], dn_c[$], dn_e[$], pr_c[$], bz_c[$], dc_c[$];
  int e_dn; bit e_err; int e_w[$];

  initial forever begin
    @(posedge clk); #1;
    done_collide = res_at[cyc] | extra_at[cyc];
  end

  initial forever begin
    @(negedge clk);
    if (in_valid) begin
      if (iv_cnt < keep) res_at[cyc + lat] = 1'b1;
      iv_cnt++;
    end
    if (rd_en) begin rd_c.push_back(cyc); rd_a.push_back(int'(rd_addr)); end
    if (wr_en) begin wr_c.push_back(cyc); wr_a.push_back(int'(wr_addr)); end
    if (done) begin dn_c.push_back(cyc); dn_e.push_back(int'(err)); end
    if (!pipe_rst_n) pr_c.push_back(cyc);
    if (busy) bz_c.push_back(cyc);
    if (done_collide) dc_c.push_back(cyc);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_caps();
    rd_c.delete(); rd_a.delete(); wr_c.delete(); wr_a.delete(); dn_c.delete();
    dn_e.delete(); pr_c.delete(); bz_c.delete(); dc_c.delete();
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 8192; i++) begin res_at[i] = 1'b0; extra_at[i] = 1'b0; end
  endtask

  task automatic start_batch(input int n, output int t);
    clear_caps();
    iv_cnt = 0;
    @(posedge clk); #1;
    num_pairs = n[7:0];
    cs = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (dn_c.size() > 0) begin ok = 1'b1; break; end
    end
  endtask

  // Expected writes/done/err from the batch rules, given the results actually presented.
  task automatic model_batch(input int t, input int n);
    int iss0, drain, res, acc, lastc, s, nv, c;
    e_w.delete(); e_dn = -1; e_err = 1'b0;
    if (n == 0) begin e_dn = t + 2; return; end
    iss0 = t + PC + 1; drain = iss0 + n; res = 0; acc = 0; lastc = -1000;
    foreach (dc_c[i]) begin
      c = dc_c[i];
      if (c <= t) continue;
      if (res == n && c > drain) begin e_dn = drain + 1; break; end
      s = (lastc + 1 > drain) ? lastc + 1 : drain;
      if (c > s + 62) begin e_dn = s + 63; e_err = 1'b1; break; end
      nv = c - 1 - iss0;
      if (nv < 0) nv = 0;
      if (nv > n) nv = n;
      if (nv - acc == 0) e_err = 1'b1; else acc++;
      if (res < n) begin e_w.push_back(c); res++; end
      lastc = c;
      if (res == n && c >= drain) begin e_dn = c + 1; break; end
    end
    if (e_dn < 0) begin
      if (res == n) e_dn = drain + 1;
      else begin
        s = (lastc + 1 > drain) ? lastc + 1 : drain;
        e_dn = s + 63; e_err = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk); #1;
    total++; if ({pipe_rst_n, rd_en, in_valid, busy, done, err, wr_en} !== 7'b1000000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 1000000", {pipe_rst_n, rd_en, in_valid, busy, done, err, wr_en}); end
    total++; if (rd_addr !== 8'd0) begin bad++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    total++; if (wr_addr !== 8'd0) begin bad++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int t; bit ok;
    lat = 5; keep = 1000;
    start_batch(4, t);
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_done_seen: got none want pulse"); end
    repeat (3) @(negedge clk); #1;
    model_batch(t, 4);
    total++; if (pr_c.size() != PC || pr_c[0] != t + 1 || pr_c[PC-1] != t + PC) begin
      bad++; $display("FAIL basic_pipe_clr: got %0d cycles want %0d from %0d", pr_c.size(), PC, t + 1); end
    for (int i = 0; i < 4; i++) begin
      total++; if (i >= rd_c.size() || rd_c[i] != t + PC + 1 + i || rd_a[i] != i) begin
        bad++; $display("FAIL basic_rd[%0d]: got size %0d want addr %0d at %0d", i, rd_c.size(), i, t + PC + 1 + i); end
    end
    total++; if (wr_c.size() != 4) begin bad++; $display("FAIL basic_wr_count: got %0d want 4", wr_c.size()); end
    for (int i = 0; i < 4 && i < wr_c.size(); i++) begin
      total++; if (wr_c[i] != t + PC + 2 + i + lat || wr_a[i] != i) begin
        bad++; $display("FAIL basic_wr[%0d]: got %0d@%0d want %0d@%0d", i, wr_a[i], wr_c[i], i, t + PC + 2 + i + lat); end
    end
    total++; if (dn_c.size() != 1 || dn_c[0] != t + 13 || dn_c[0] != e_dn) begin
      bad++; $display("FAIL basic_done_cycle: got %0d want %0d", (dn_c.size() > 0) ? dn_c[0] : -1, t + 13); end
    total++; if (dn_e.size() != 1 || dn_e[0] != 0) begin bad++; $display("FAIL basic_err: got err want 0"); end
    total++; if (bz_c.size() != 12 || bz_c[0] != t + 1) begin
      bad++; $display("FAIL basic_busy: got %0d cycles want 12", bz_c.size()); end
  endtask

  task automatic test_zero();
    int t; bit ok;
    start_batch(0, t);
    wait_done(20, ok);
    repeat (2) @(negedge clk); #1;
    total++; if (!ok || dn_c[0] != t + 2) begin
      bad++; $display("FAIL zero_done: got %0d want %0d", ok ? dn_c[0] : -1, t + 2); end
    total++; if (rd_c.size() + pr_c.size() + bz_c.size() + wr_c.size() != 0) begin
      bad++; $display("FAIL zero_activity: got rd=%0d pr=%0d bz=%0d wr=%0d want 0", rd_c.size(), pr_c.size(), bz_c.size(), wr_c.size()); end
    total++; if (dn_c.size() != 1 || err !== 1'b0) begin
      bad++; $display("FAIL zero_single_done: got %0d err=%b want 1 err=0", dn_c.size(), err); end
  endtask

  task automatic test_hold();
    int t, t2; bit ok;
    lat = 5; keep = 1000;
    clear_caps(); iv_cnt = 0;
    @(posedge clk); #1;
    num_pairs = 8'd3; cs = 1'b1; t = cyc;
    repeat (50) @(posedge clk);
    #1 cs = 1'b0;
    total++; if (dn_c.size() != 1 || rd_c.size() != 3) begin
      bad++; $display("FAIL hold_single_batch: got done=%0d rd=%0d want 1 3", dn_c.size(), rd_c.size()); end
    total++; if (dn_c.size() < 1 || dn_c[0] != t + 12) begin
      bad++; $display("FAIL hold_done_cycle: got %0d want %0d", (dn_c.size() > 0) ? dn_c[0] : -1, t + 12); end
    start_batch(3, t2);
    wait_done(100, ok);
    total++; if (!ok || dn_c[0] != t2 + 12 || rd_c.size() != 3 || rd_a[0] != 0) begin
      bad++; $display("FAIL hold_second_batch: got done=%0d rd=%0d want %0d 3", ok ? dn_c[0] : -1, rd_c.size(), t2 + 12); end
  endtask

  task automatic test_timeout();
    int t, t2; bit ok;
    lat = 5; keep = 2;
    start_batch(3, t);
    wait_done(200, ok);
    keep = 1000;
    model_batch(t, 3);
    total++; if (!ok || dn_c[0] != e_dn) begin
      bad++; $display("FAIL tmo_done: got %0d want %0d", ok ? dn_c[0] : -1, e_dn); end
    total++; if (!ok || dc_c.size() != 2 || dn_c[0] - dc_c[1] != 64) begin
      bad++; $display("FAIL tmo_gap: got results=%0d want 64-cycle gap after 2nd", dc_c.size()); end
    total++; if (!ok || dn_e[0] != 1) begin bad++; $display("FAIL tmo_err: got 0 want 1"); end
    total++; if (wr_c.size() != 2) begin bad++; $display("FAIL tmo_writes: got %0d want 2", wr_c.size()); end
    repeat (2) @(negedge clk);
    start_batch(1, t2);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_err_clear: got %b want 0", err); end
    wait_done(100, ok);
    total++; if (!ok || dn_e[0] != 0) begin bad++; $display("FAIL tmo_next_batch: got err/none want clean done"); end
  endtask

  task automatic test_spurious();
    int t; bit ok; int mx;
    lat = 5; keep = 1000;
    start_batch(4, t);
    extra_at[t + PC + 1] = 1'b1;
    wait_done(100, ok);
    repeat (lat + 2) @(negedge clk); #1;
    model_batch(t, 4);
    total++; if (!ok || dn_e[0] != 1) begin bad++; $display("FAIL spur_err: got 0 want 1"); end
    total++; if (!ok || dn_c[0] != e_dn) begin
      bad++; $display("FAIL spur_done: got %0d want %0d", ok ? dn_c[0] : -1, e_dn); end
    mx = -1;
    foreach (wr_a[i]) if (wr_a[i] > mx) mx = wr_a[i];
    total++; if (wr_c.size() != 4 || mx != 3) begin
      bad++; $display("FAIL spur_writes: got %0d max %0d want 4 max 3", wr_c.size(), mx); end
    for (int i = 0; i < e_w.size() && i < wr_c.size(); i++) begin
      total++; if (wr_c[i] != e_w[i] || wr_a[i] != i) begin
        bad++; $display("FAIL spur_wr[%0d]: got %0d@%0d want %0d@%0d", i, wr_a[i], wr_c[i], i, e_w[i]); end
    end
  endtask

  task automatic test_rst_mid();
    int t, t2; bit ok;
    lat = 5; keep = 1000;
    start_batch(8, t);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (rd_c.size() >= 3) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL rst_reads_seen: got %0d want 3", rd_c.size()); end
    #2 rst = 1'b0;
    #1;
    total++; if ({pipe_rst_n, rd_en, in_valid, busy, done, err, wr_en} !== 7'b1000000 || rd_addr !== 8'd0) begin
      bad++; $display("FAIL rst_async: got %b addr %0d want 1000000 addr 0", {pipe_rst_n, rd_en, in_valid, busy, done, err, wr_en}, rd_addr); end
    repeat (4) @(negedge clk); #1;
    total++; if (dn_c.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_no_done: got %0d want 0", dn_c.size()); end
    clear_sched();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    start_batch(3, t2);
    wait_done(100, ok);
    total++; if (!ok || rd_c.size() != 3 || rd_a[0] != 0 || rd_c[0] != t2 + PC + 1 || dn_c[0] != t2 + 12) begin
      bad++; $display("FAIL rst_fresh_batch: got rd=%0d done=%0d want 3 %0d", rd_c.size(), ok ? dn_c[0] : -1, t2 + 12); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, d1; bit ok;
    lat = 3; keep = 1000;
    start_batch(2, t1);
    wait_done(100, ok);
    d1 = ok ? dn_c[0] : -1;
    total++; if (d1 != t1 + PC + 1 + 2 + lat + 1) begin
      bad++; $display("FAIL b2b_first_done: got %0d want %0d", d1, t1 + PC + 4 + lat); end
    start_batch(2, t2);
    wait_done(100, ok);
    repeat (lat + 2) @(negedge clk); #1;
    model_batch(t2, 2);
    total++; if (!ok || dn_c[0] != e_dn || rd_c.size() != 2 || rd_c[0] != t2 + PC + 1 || rd_a[0] != 0) begin
      bad++; $display("FAIL b2b_second: got done=%0d rd=%0d want done=%0d rd=2", ok ? dn_c[0] : -1, rd_c.size(), e_dn); end
  endtask

  task automatic test_random();
    int t, n; bit ok;
    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(1, 12);
      lat = $urandom_range(1, 8);
      keep = ($urandom_range(0, 7) == 0) ? n - 1 : 1000;
      start_batch(n, t);
      if ($urandom_range(0, 3) == 0) extra_at[t + $urandom_range(2, PC + n + lat + 1)] = 1'b1;
      wait_done(200, ok);
      repeat (lat + 3) @(negedge clk); #1;
      keep = 1000;
      model_batch(t, n);
      total++; if (!ok || dn_c.size() != 1 || dn_c[0] != e_dn || dn_e[0] != int'(e_err)) begin
        bad++; $display("FAIL rnd%0d_done: got %0d err %0d want %0d err %0d", k, ok ? dn_c[0] : -1, ok ? dn_e[0] : -1, e_dn, e_err); end
      total++; if (wr_c.size() != e_w.size()) begin
        bad++; $display("FAIL rnd%0d_wr_count: got %0d want %0d", k, wr_c.size(), e_w.size()); end
      for (int i = 0; i < e_w.size() && i < wr_c.size(); i++) begin
        total++; if (wr_c[i] != e_w[i] || wr_a[i] != i) begin
          bad++; $display("FAIL rnd%0d_wr[%0d]: got %0d@%0d want %0d@%0d", k, i, wr_a[i], wr_c[i], i, e_w[i]); end
      end
      total++; if (rd_c.size() != n || rd_a[n-1] != n - 1 || rd_c[n-1] != t + PC + n) begin
        bad++; $display("FAIL rnd%0d_rd: got %0d reads want %0d", k, rd_c.size(), n); end
      total++; if (bz_c.size() != e_dn - 1 - t) begin
        bad++; $display("FAIL rnd%0d_busy: got %0d want %0d", k, bz_c.size(), e_dn - 1 - t); end
    end
  endtask

  initial begin
    clear_sched();
    test_reset();
    test_basic();
    test_zero();
    test_hold();
    test_timeout();
    test_spurious();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
